// File: rtl/riscv_pkg.sv
// Shared front-end types: fetch packet layout and pre-decode helpers
// used by the fetch/decode instruction queue.
package riscv_pkg;

    localparam int XLEN_MSB = 31;
    localparam int GHR_MSB  = 7;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN_MSB:0] instruction;
        logic [XLEN_MSB:0] instrPC;
        logic [XLEN_MSB:0] predictedPC;
        logic [GHR_MSB:0]  GHRIndex;
        logic [1:0]        PHTState;
        logic              redirect;
    } fetch_packet_t;

    function automatic logic is_branch(input logic [6:0] opcode);
        return opcode == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Bundle of fetch-side, decode-side and misdirect signals around the
// instruction queue; slave is the queue, master is its environment.
interface fetch_decode_queue_if #(
    parameter int WIDTH = 31,
    parameter int INDEX = 7,
    parameter int DEPTH = 4
);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic             flush;
    logic             fetchValid;
    logic             fetchReady;
    logic [WIDTH:0]   instruction;
    logic [WIDTH:0]   instrPC;
    logic [WIDTH:0]   predictedPCF;
    logic [INDEX:0]   GHRIndex;
    logic [1:0]       PHTState;
    logic             redirect;
    logic             deqReady;
    logic             deqValid;
    logic [WIDTH:0]   deqInstr;
    logic [WIDTH:0]   deqPC;
    logic [WIDTH:0]   deqPredPC;
    logic [INDEX:0]   deqGHR;
    logic [1:0]       deqState;
    logic             deqRedirect;
    logic             misdirectValid;
    logic [WIDTH:0]   misdirectPC;
    logic [CNTW-1:0]  count;

    modport master (
        output flush, fetchValid, instruction, instrPC, predictedPCF,
               GHRIndex, PHTState, redirect, deqReady,
        input  fetchReady, deqValid, deqInstr, deqPC, deqPredPC, deqGHR,
               deqState, deqRedirect, misdirectValid, misdirectPC, count
    );

    modport slave (
        input  flush, fetchValid, instruction, instrPC, predictedPCF,
               GHRIndex, PHTState, redirect, deqReady,
        output fetchReady, deqValid, deqInstr, deqPC, deqPredPC, deqGHR,
               deqState, deqRedirect, misdirectValid, misdirectPC, count
    );

endinterface

// File: rtl/fq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the instruction queue, including
// flush and misdirect truncation of younger entries.
module fq_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         fetch_valid,
    input  logic                         deq_ready,
    input  logic                         head_bad,
    output logic [$clog2(DEPTH)-1:0]     head,
    output logic [$clog2(DEPTH)-1:0]     tail,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         deq_valid,
    output logic                         enq_fire,
    output logic                         deq_fire,
    output logic                         discard
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [DEPTH-1:0] slot_vld;
    logic             empty;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign deq_valid = !empty && slot_vld[head];
    assign enq_fire  = fetch_valid && !full;
    assign deq_fire  = deq_valid && deq_ready;
    // A popped misdirect throws away every younger entry and any same-cycle fetch.
    assign discard   = deq_fire && head_bad && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else if (discard) begin
            head     <= head + PW'(1);
            tail     <= head + PW'(1);
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (enq_fire) begin
                tail           <= tail + PW'(1);
                slot_vld[tail] <= 1'b1;
            end
            if (deq_fire) begin
                head           <= head + PW'(1);
                slot_vld[head] <= 1'b0;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// First-word-fall-through instruction buffer between fetch and decode with
// dequeue-time detection of predicted-taken non-branches.
module fetch_decode_queue
    import riscv_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int INDEX = 7,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  globalReset,
    fetch_decode_queue_if.slave   fq
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH:0] instruction;
        logic [WIDTH:0] instr_pc;
        logic [WIDTH:0] pred_pc;
        logic [INDEX:0] ghr;
        logic [1:0]     pht;
        logic           redirect;
    } slot_t;

    slot_t            mem [DEPTH];
    slot_t            head_pkt;
    slot_t            tail_pkt;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CNTW-1:0]  count;
    logic             full;
    logic             deq_valid;
    logic             enq_fire;
    logic             deq_fire;
    logic             discard;
    logic             head_is_branch;
    logic             head_bad;
    logic             mis_vld_p1;
    logic [WIDTH:0]   mis_pc_p1;

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk         (clk),
        .rst_n       (globalReset),
        .flush       (fq.flush),
        .fetch_valid (fq.fetchValid),
        .deq_ready   (fq.deqReady),
        .head_bad    (head_bad),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .full        (full),
        .deq_valid   (deq_valid),
        .enq_fire    (enq_fire),
        .deq_fire    (deq_fire),
        .discard     (discard)
    );

    assign tail_pkt = '{instruction: fq.instruction, instr_pc: fq.instrPC,
                        pred_pc: fq.predictedPCF, ghr: fq.GHRIndex,
                        pht: fq.PHTState, redirect: fq.redirect};

    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[tail] <= tail_pkt;
    end

    assign head_pkt       = mem[head];
    assign head_is_branch = is_branch(head_pkt.instruction[6:0]);
    assign head_bad       = head_pkt.redirect && !head_is_branch;

    // Corrective fetch PC is registered: one-cycle pulse after the pop.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            mis_vld_p1 <= 1'b0;
            mis_pc_p1  <= '0;
        end else begin
            mis_vld_p1 <= discard;
            if (discard)
                mis_pc_p1 <= head_pkt.instr_pc + (WIDTH+1)'(4);
        end
    end

    assign fq.fetchReady     = !full;
    assign fq.deqValid       = deq_valid;
    assign fq.deqInstr       = head_pkt.instruction;
    assign fq.deqPC          = head_pkt.instr_pc;
    assign fq.deqPredPC      = head_pkt.pred_pc;
    assign fq.deqGHR         = head_pkt.ghr;
    assign fq.deqState       = head_pkt.pht;
    assign fq.deqRedirect    = head_pkt.redirect && head_is_branch;
    assign fq.misdirectValid = mis_vld_p1;
    assign fq.misdirectPC    = mis_pc_p1;
    assign fq.count          = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: vector table plus hand-written
// asynchronous reset sequences.
module tb_fetch_decode_queue;
    import riscv_pkg::*;

    localparam int WIDTH = 31;
    localparam int INDEX = 7;
    localparam int DEPTH = 4;
    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_decode_queue_if #(.WIDTH(WIDTH), .INDEX(INDEX), .DEPTH(DEPTH)) fq ();

    fetch_decode_queue #(.WIDTH(WIDTH), .INDEX(INDEX), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .globalReset (rst_n),
        .fq          (fq.slave)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        br;
        logic        rd;
        logic        dr;
        logic        fl;
        int          e_cnt;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic        e_drd;
        logic        e_mv;
        logic [31:0] e_mpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic fv, input logic [31:0] pc,
                               input logic br, input logic rd,
                               input logic dr, input logic fl,
                               input int cnt, input logic dv,
                               input logic [31:0] dpc, input logic drd,
                               input logic mv, input logic [31:0] mpc);
        vec_t r;
        r.fv = fv; r.pc = pc; r.br = br; r.rd = rd; r.dr = dr; r.fl = fl;
        r.e_cnt = cnt; r.e_dv = dv; r.e_dpc = dpc; r.e_drd = drd;
        r.e_mv = mv; r.e_mpc = mpc;
        return r;
    endfunction

    function automatic fetch_packet_t mk(input logic [31:0] pc, input logic br,
                                         input logic rd);
        fetch_packet_t p;
        p.instruction = br ? BEQ : ADDI;
        p.instrPC     = pc;
        p.predictedPC = pc ^ 32'hF000_0000;
        p.GHRIndex    = pc[9:2];
        p.PHTState    = pc[3:2];
        p.redirect    = rd;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic br,
                         input logic rd, input logic dr, input logic fl);
        fetch_packet_t p;
        p = mk(pc, br, rd);
        fq.fetchValid   = fv;
        fq.instruction  = p.instruction;
        fq.instrPC      = p.instrPC;
        fq.predictedPCF = p.predictedPC;
        fq.GHRIndex     = p.GHRIndex;
        fq.PHTState     = p.PHTState;
        fq.redirect     = p.redirect;
        fq.deqReady     = dr;
        fq.flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset count",      32'(fq.count),          32'd0);
        check("reset fetchReady", 32'(fq.fetchReady),     32'd1);
        check("reset deqValid",   32'(fq.deqValid),       32'd0);
        check("reset misValid",   32'(fq.misdirectValid), 32'd0);
        check("reset misPC",      32'(fq.misdirectPC),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //               fv pc            br rd dr fl cnt dv dpc           drd mv mpc
        tbl.push_back(v(1, 32'h00,       0, 0, 0, 0, 1, 1, 32'h00,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h04,       0, 0, 0, 0, 2, 1, 32'h00,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h08,       0, 0, 0, 0, 3, 1, 32'h00,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h0C,       0, 0, 0, 0, 4, 1, 32'h00,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h10,       0, 0, 0, 0, 4, 1, 32'h00,       0, 0, 32'h0));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 3, 1, 32'h04,       0, 0, 32'h0));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 2, 1, 32'h08,       0, 0, 32'h0));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 1, 1, 32'h0C,       0, 0, 32'h0));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 0, 0, 32'h00,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h20,       0, 0, 0, 0, 1, 1, 32'h20,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h24,       0, 0, 0, 0, 2, 1, 32'h20,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h28,       0, 0, 1, 0, 2, 1, 32'h24,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h2C,       0, 0, 1, 0, 2, 1, 32'h28,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h30,       0, 0, 1, 0, 2, 1, 32'h2C,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h34,       0, 0, 1, 0, 2, 1, 32'h30,       0, 0, 32'h0));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 1, 1, 32'h34,       0, 0, 32'h0));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 0, 0, 32'h00,       0, 0, 32'h0));
        // misdirect head held while decode is frozen, then popped with a fetch
        tbl.push_back(v(1, 32'h40,       0, 1, 0, 0, 1, 1, 32'h40,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h44,       0, 0, 0, 0, 2, 1, 32'h40,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h48,       0, 0, 0, 0, 3, 1, 32'h40,       0, 0, 32'h0));
        tbl.push_back(v(1, 32'h80,       0, 0, 1, 0, 0, 0, 32'h00,       0, 1, 32'h44));
        tbl.push_back(v(0, 32'h00,       0, 0, 0, 0, 0, 0, 32'h00,       0, 0, 32'h44));
        // genuine predicted-taken branch
        tbl.push_back(v(1, 32'h50,       1, 1, 0, 0, 1, 1, 32'h50,       1, 0, 32'h44));
        tbl.push_back(v(1, 32'h54,       0, 0, 0, 0, 2, 1, 32'h50,       1, 0, 32'h44));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 1, 1, 32'h54,       0, 0, 32'h44));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 0, 0, 32'h00,       0, 0, 32'h44));
        // flush with concurrent enqueue and dequeue
        tbl.push_back(v(1, 32'h60,       0, 0, 0, 0, 1, 1, 32'h60,       0, 0, 32'h44));
        tbl.push_back(v(1, 32'h64,       0, 0, 0, 0, 2, 1, 32'h60,       0, 0, 32'h44));
        tbl.push_back(v(1, 32'h68,       0, 0, 0, 0, 3, 1, 32'h60,       0, 0, 32'h44));
        tbl.push_back(v(1, 32'h6C,       0, 0, 1, 1, 0, 0, 32'h00,       0, 0, 32'h44));
        tbl.push_back(v(0, 32'h00,       0, 0, 0, 0, 0, 0, 32'h00,       0, 0, 32'h44));
        tbl.push_back(v(1, 32'h70,       0, 0, 0, 0, 1, 1, 32'h70,       0, 0, 32'h44));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 0, 0, 32'h00,       0, 0, 32'h44));
        // corrective PC wraps at the top of the address space
        tbl.push_back(v(1, 32'hFFFFFFFC, 0, 1, 0, 0, 1, 1, 32'hFFFFFFFC, 0, 0, 32'h44));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 0, 0, 0, 32'h00,       0, 1, 32'h00));
        tbl.push_back(v(0, 32'h00,       0, 0, 0, 0, 0, 0, 32'h00,       0, 0, 32'h00));
        // flush outranks a misdirect pop
        tbl.push_back(v(1, 32'hA0,       0, 1, 0, 0, 1, 1, 32'hA0,       0, 0, 32'h00));
        tbl.push_back(v(0, 32'h00,       0, 0, 1, 1, 0, 0, 32'h00,       0, 0, 32'h00));
        tbl.push_back(v(0, 32'h00,       0, 0, 0, 0, 0, 0, 32'h00,       0, 0, 32'h00));
        tbl.push_back(v(1, 32'hB0,       0, 0, 0, 0, 1, 1, 32'hB0,       0, 0, 32'h00));
        tbl.push_back(v(1, 32'hB4,       0, 0, 0, 0, 2, 1, 32'hB0,       0, 0, 32'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fv, tbl[i].pc, tbl[i].br, tbl[i].rd, tbl[i].dr, tbl[i].fl);
            tick();
            check($sformatf("v%0d count", i),      32'(fq.count), 32'(tbl[i].e_cnt));
            check($sformatf("v%0d fetchReady", i), 32'(fq.fetchReady),
                  32'(tbl[i].e_cnt != DEPTH));
            check($sformatf("v%0d deqValid", i),   32'(fq.deqValid), 32'(tbl[i].e_dv));
            check($sformatf("v%0d misValid", i),   32'(fq.misdirectValid), 32'(tbl[i].e_mv));
            check($sformatf("v%0d misPC", i),      fq.misdirectPC, tbl[i].e_mpc);
            if (tbl[i].e_dv) begin
                check($sformatf("v%0d deqPC", i),       fq.deqPC, tbl[i].e_dpc);
                check($sformatf("v%0d deqRedirect", i), 32'(fq.deqRedirect), 32'(tbl[i].e_drd));
                check($sformatf("v%0d deqPredPC", i),   fq.deqPredPC,
                      tbl[i].e_dpc ^ 32'hF000_0000);
                check($sformatf("v%0d deqGHR", i),      32'(fq.deqGHR), 32'(tbl[i].e_dpc[9:2]));
                check($sformatf("v%0d deqState", i),    32'(fq.deqState), 32'(tbl[i].e_dpc[3:2]));
            end
        end

        // asynchronous reset with two entries queued, between clock edges
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst1 count",      32'(fq.count),      32'd0);
        check("arst1 deqValid",   32'(fq.deqValid),   32'd0);
        check("arst1 fetchReady", 32'(fq.fetchReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // asynchronous reset while a misdirect pulse is pending
        drive(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("arst2 setup count", 32'(fq.count), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("arst2 misValid pre", 32'(fq.misdirectValid), 32'd1);
        check("arst2 misPC pre",    fq.misdirectPC,         32'hC4);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst2 misValid", 32'(fq.misdirectValid), 32'd0);
        check("arst2 misPC",    fq.misdirectPC,         32'd0);
        check("arst2 count",    32'(fq.count),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("post count", 32'(fq.count), 32'd1);
        check("post deqPC", fq.deqPC,      32'hD0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
